// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the single-cycle 8-bit CPU: instruction/data memories,
// byte-stream program loader, store counter and misaligned-fetch fault handling.
module cpu_mem_responder #(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256,
    parameter int CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             RESET_L,
    input  logic [7:0]       PC,
    output logic [15:0]      Iin,
    input  logic [7:0]       MADDR,
    input  logic [7:0]       MWDATA,
    input  logic             MW,
    output logic [7:0]       Din,
    output logic             EN_L,
    input  logic             LD_VALID,
    input  logic [7:0]       LD_DATA,
    input  logic             LD_LAST,
    output logic             LD_READY,
    input  logic             STOP,
    output logic             LD_OVF,
    output logic             FAULT,
    output logic [CNT_W-1:0] STORE_CNT
);
    localparam int IA_W = $clog2(IMEM_DEPTH);
    localparam int DA_W = $clog2(DMEM_DEPTH);
    localparam logic [IA_W-1:0] PTR_MAX = IA_W'(IMEM_DEPTH - 1);

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_RUN     = 2'd1,
        S_FAULTED = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [IA_W-1:0]   r_ptr;
    logic [IA_W-1:0]   w_ptr_next;
    logic              r_ld_ovf;
    logic              w_ld_ovf_next;
    logic              r_fault;
    logic              w_fault_next;
    logic [CNT_W-1:0]  r_store_cnt;
    logic [CNT_W-1:0]  w_store_cnt_next;
    logic              w_imem_we;
    logic              w_dmem_we;

    logic [7:0] r_imem [IMEM_DEPTH];
    logic [7:0] r_dmem [DMEM_DEPTH];

    logic [IA_W-1:0] w_fetch_hi;
    logic [IA_W-1:0] w_fetch_lo;
    logic [DA_W-1:0] w_daddr;

    // Low fetch byte address wraps naturally in the IA_W-bit adder.
    assign w_fetch_hi = PC[IA_W-1:0];
    assign w_fetch_lo = w_fetch_hi + 1'b1;
    assign w_daddr    = MADDR[DA_W-1:0];

    assign Iin       = {r_imem[w_fetch_hi], r_imem[w_fetch_lo]};
    assign Din       = r_dmem[w_daddr];
    assign EN_L      = (r_state != S_RUN);
    assign LD_READY  = (r_state == S_LOAD);
    assign LD_OVF    = r_ld_ovf;
    assign FAULT     = r_fault;
    assign STORE_CNT = r_store_cnt;

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            r_state     <= S_LOAD;
            r_ptr       <= '0;
            r_ld_ovf    <= 1'b0;
            r_fault     <= 1'b0;
            r_store_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_ptr       <= w_ptr_next;
            r_ld_ovf    <= w_ld_ovf_next;
            r_fault     <= w_fault_next;
            r_store_cnt <= w_store_cnt_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_ptr_next       = r_ptr;
        w_ld_ovf_next    = r_ld_ovf;
        w_fault_next     = r_fault;
        w_store_cnt_next = r_store_cnt;
        w_imem_we        = 1'b0;
        w_dmem_we        = 1'b0;

        case (r_state)
            S_LOAD: begin
                w_imem_we = LD_VALID;
                if (LD_VALID) begin
                    w_ptr_next = r_ptr + 1'b1;
                    if (r_ptr == PTR_MAX) begin
                        w_ld_ovf_next = 1'b1;
                    end
                    if (LD_LAST) begin
                        w_state_next = S_RUN;
                        w_ptr_next   = '0;
                    end
                end
                // STOP wins over a final byte: the byte lands but we stay loading.
                if (STOP) begin
                    w_state_next  = S_LOAD;
                    w_ptr_next    = '0;
                    w_ld_ovf_next = 1'b0;
                end
            end
            S_RUN: begin
                w_dmem_we = MW;
                if (MW && !(&r_store_cnt)) begin
                    w_store_cnt_next = r_store_cnt + 1'b1;
                end
                if (STOP) begin
                    w_state_next  = S_LOAD;
                    w_ptr_next    = '0;
                    w_fault_next  = 1'b0;
                    w_ld_ovf_next = 1'b0;
                end else if (PC[0]) begin
                    w_state_next = S_FAULTED;
                    w_fault_next = 1'b1;
                end
            end
            S_FAULTED: begin
                if (STOP) begin
                    w_state_next  = S_LOAD;
                    w_ptr_next    = '0;
                    w_fault_next  = 1'b0;
                    w_ld_ovf_next = 1'b0;
                end
            end
            default: begin
                w_state_next = S_LOAD;
            end
        endcase
    end

    // Memories carry no reset so a partial load survives RESET_L.
    always_ff @(posedge CLK) begin
        if (w_imem_we) begin
            r_imem[r_ptr] <= LD_DATA;
        end
        if (w_dmem_we) begin
            r_dmem[w_daddr] <= MWDATA;
        end
    end
endmodule
